// File: rtl/command_scheduler_pkg.sv
// Shared types for the NPU command scheduler: opcodes, unit indices, FSM states
// and the queued command record.
package command_scheduler_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_MATMUL = 3'd3,
    OP_ACT    = 3'd4,
    OP_SYNC   = 3'd5,
    OP_RSVD   = 3'd6,
    OP_HALT   = 3'd7
  } opcode_e;

  localparam int unsigned UNIT_DMA  = 0;
  localparam int unsigned UNIT_MAC  = 1;
  localparam int unsigned UNIT_VEC  = 2;
  localparam int unsigned NUM_UNITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SYNC_WAIT,
    ST_HALTED
  } state_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] param1;
    logic [31:0] param2;
  } cmd_t;

  // Non-unit opcodes map to DMA; callers only use the result for unit opcodes.
  function automatic logic [1:0] unit_of(opcode_e op);
    case (op)
      OP_MATMUL: return 2'(UNIT_MAC);
      OP_ACT:    return 2'(UNIT_VEC);
      default:   return 2'(UNIT_DMA);
    endcase
  endfunction

endpackage

// File: rtl/command_scheduler_if.sv
// Command input and unit issue/completion bus of the scheduler.
interface command_scheduler_if;
  import command_scheduler_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_opcode;
  logic [31:0]          in_src_addr;
  logic [31:0]          in_dst_addr;
  logic [31:0]          in_param1;
  logic [31:0]          in_param2;
  logic [NUM_UNITS-1:0] unit_valid;
  logic [NUM_UNITS-1:0] unit_ready;
  logic [NUM_UNITS-1:0] unit_done;
  logic [31:0]          unit_src_addr;
  logic [31:0]          unit_dst_addr;
  logic [31:0]          unit_param1;
  logic [31:0]          unit_param2;
  logic                 unit_is_store;

  // Scheduler view
  modport slave (
    input  in_valid, in_opcode, in_src_addr, in_dst_addr, in_param1, in_param2,
    input  unit_ready, unit_done,
    output in_ready, unit_valid, unit_src_addr, unit_dst_addr, unit_param1,
    output unit_param2, unit_is_store
  );

  // Decoder and execution-unit view
  modport master (
    output in_valid, in_opcode, in_src_addr, in_dst_addr, in_param1, in_param2,
    output unit_ready, unit_done,
    input  in_ready, unit_valid, unit_src_addr, unit_dst_addr, unit_param1,
    input  unit_param2, unit_is_store
  );

endinterface

// File: rtl/command_scheduler_cmd_queue.sv
// Synchronous FIFO holding decoded commands; caller never pushes when full
// nor pops when empty.
module cmd_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 131
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/command_scheduler.sv
// In-order NPU command scheduler: queues decoded commands, dispatches them to
// DMA / compute / vector units, tracks unit busy state, SYNC barriers and HALT.
module command_scheduler
  import command_scheduler_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned SYNC_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  command_scheduler_if.slave           bus,
  input  logic                         resume,
  output logic                         busy,
  output logic                         halted,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level,
  output logic                         err_illegal,
  output logic                         err_spurious,
  output logic                         err_timeout
);

  localparam int unsigned CW = $clog2(SYNC_TIMEOUT + 1);

  state_e               state, state_next;
  cmd_t                 q_din, q_dout;
  logic                 q_full, q_empty, push, pop;
  logic [NUM_UNITS-1:0] unit_busy, set_busy;
  logic [1:0]           issue_unit, target;
  logic                 issue, handshake, set_illegal, set_timeout;
  logic [CW-1:0]        sync_cnt;

  assign q_din = '{opcode:   opcode_e'(bus.in_opcode),
                   src_addr: bus.in_src_addr,
                   dst_addr: bus.in_dst_addr,
                   param1:   bus.in_param1,
                   param2:   bus.in_param2};

  assign bus.in_ready = !q_full && (state != ST_HALTED);
  assign push         = bus.in_valid && bus.in_ready;

  cmd_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH($bits(cmd_t))) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .level (queue_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    issue       = 1'b0;
    handshake   = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    issue_unit  = unit_of(q_dout.opcode);
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          case (q_dout.opcode)
            OP_NOP: pop = 1'b1;
            OP_LOAD, OP_STORE, OP_MATMUL, OP_ACT: begin
              // Strict in-order: a busy target stalls the whole queue.
              if (!unit_busy[issue_unit]) begin
                pop        = 1'b1;
                issue      = 1'b1;
                state_next = ST_ISSUE;
              end
            end
            OP_SYNC: begin
              pop        = 1'b1;
              state_next = ST_SYNC_WAIT;
            end
            OP_HALT: begin
              pop        = 1'b1;
              state_next = ST_HALTED;
            end
            default: begin
              pop         = 1'b1;
              set_illegal = 1'b1;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        if (bus.unit_ready[target]) begin
          handshake  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_SYNC_WAIT: begin
        if (unit_busy == '0) begin
          state_next = ST_IDLE;
        end else if (sync_cnt == CW'(SYNC_TIMEOUT - 1)) begin
          set_timeout = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (resume) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // unit_valid is one-hot while issuing, so it doubles as the busy-set mask.
  assign set_busy = handshake ? bus.unit_valid : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.unit_valid    <= '0;
      bus.unit_src_addr <= '0;
      bus.unit_dst_addr <= '0;
      bus.unit_param1   <= '0;
      bus.unit_param2   <= '0;
      bus.unit_is_store <= 1'b0;
      target            <= '0;
      unit_busy         <= '0;
      sync_cnt          <= '0;
      err_illegal       <= 1'b0;
      err_spurious      <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      if (issue) begin
        target            <= issue_unit;
        bus.unit_valid    <= {{(NUM_UNITS-1){1'b0}}, 1'b1} << issue_unit;
        bus.unit_src_addr <= q_dout.src_addr;
        bus.unit_dst_addr <= q_dout.dst_addr;
        bus.unit_param1   <= q_dout.param1;
        bus.unit_param2   <= q_dout.param2;
        bus.unit_is_store <= (q_dout.opcode == OP_STORE);
      end else if (handshake) begin
        bus.unit_valid <= '0;
      end
      unit_busy <= (unit_busy & ~bus.unit_done) | set_busy;
      if ((bus.unit_done & ~unit_busy) != '0) err_spurious <= 1'b1;
      if (set_illegal) err_illegal <= 1'b1;
      if (set_timeout) err_timeout <= 1'b1;
      if (state == ST_SYNC_WAIT) sync_cnt <= sync_cnt + CW'(1);
      else                       sync_cnt <= '0;
    end
  end

  assign busy   = !q_empty || (unit_busy != '0) || (state == ST_ISSUE);
  assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_command_scheduler.sv
// Directed self-checking bench for command_scheduler (QUEUE_DEPTH=4, SYNC_TIMEOUT=1024).
module tb_command_scheduler;

  logic       clk;
  logic       rst;
  logic       resume;
  logic       busy;
  logic       halted;
  logic [2:0] queue_level;
  logic       err_illegal, err_spurious, err_timeout;
  int         checks;
  int         errors;

  command_scheduler_if bus();

  command_scheduler #(.QUEUE_DEPTH(4), .SYNC_TIMEOUT(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .resume       (resume),
    .busy         (busy),
    .halted       (halted),
    .queue_level  (queue_level),
    .err_illegal  (err_illegal),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [31:0] src, input logic [31:0] dst);
    int n;
    bus.in_opcode   = op;
    bus.in_src_addr = src;
    bus.in_dst_addr = dst;
    bus.in_param1   = src ^ 32'hA5A5_0000;
    bus.in_param2   = dst ^ 32'h0000_5A5A;
    bus.in_valid    = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL push_timeout op=%0d in_ready got %b exp 1", op, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++;
    if (bus.unit_valid !== 3'b000 || queue_level !== 3'd0 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b lvl=%0d busy=%b halted=%b exp 000/0/0/0",
               bus.unit_valid, queue_level, busy, halted);
    end
    checks++;
    if ({err_illegal, err_spurious, err_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_errors got %b exp 000", {err_illegal, err_spurious, err_timeout});
    end
  endtask

  task automatic test_load();
    bus.unit_ready = 3'b111;
    push_cmd(3'd1, 32'h100, 32'h200);
    checks++;
    if (queue_level !== 3'd1 || bus.unit_valid !== 3'b000) begin
      errors++;
      $display("FAIL load_queued got lvl=%0d valid=%b exp 1/000", queue_level, bus.unit_valid);
    end
    tick();
    checks++;
    if (bus.unit_valid !== 3'b001 || bus.unit_src_addr !== 32'h100 || bus.unit_dst_addr !== 32'h200 ||
        bus.unit_is_store !== 1'b0 || queue_level !== 3'd0) begin
      errors++;
      $display("FAIL load_issue got valid=%b src=%h dst=%h st=%b lvl=%0d exp 001/100/200/0/0",
               bus.unit_valid, bus.unit_src_addr, bus.unit_dst_addr, bus.unit_is_store, queue_level);
    end
    tick();
    checks++;
    if (bus.unit_valid !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_after_hs got valid=%b busy=%b exp 000/1", bus.unit_valid, busy);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_hold got %b exp 1", busy); end
    bus.unit_done = 3'b001;
    tick();
    bus.unit_done = 3'b000;
    checks++;
    if (busy !== 1'b0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL load_done got busy=%b spur=%b exp 0/0", busy, err_spurious);
    end
  endtask

  task automatic test_issue_stall();
    bit stable;
    bus.unit_ready = 3'b000;
    push_cmd(3'd3, 32'h11, 32'h22);
    push_cmd(3'd4, 32'h33, 32'h44);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.unit_valid !== 3'b010 || bus.unit_src_addr !== 32'h11 || bus.unit_param1 !== (32'h11 ^ 32'hA5A5_0000))
        stable = 1'b0;
      if (i < 4) tick();
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL matmul_hold got valid=%b src=%h exp 010/11 for 5 cycles", bus.unit_valid, bus.unit_src_addr);
    end
    bus.unit_ready = 3'b111;
    tick();
    checks++;
    if (bus.unit_valid !== 3'b000) begin errors++; $display("FAIL matmul_hs got %b exp 000", bus.unit_valid); end
    tick();
    checks++;
    if (bus.unit_valid !== 3'b100 || bus.unit_src_addr !== 32'h33 || bus.unit_dst_addr !== 32'h44) begin
      errors++;
      $display("FAIL act_issue got valid=%b src=%h dst=%h exp 100/33/44", bus.unit_valid, bus.unit_src_addr, bus.unit_dst_addr);
    end
    tick();
    bus.unit_done = 3'b110;
    tick();
    bus.unit_done = 3'b000;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_cleanup_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit early;
    bus.unit_ready = 3'b111;
    push_cmd(3'd1, 32'hA0, 32'hB0);
    push_cmd(3'd2, 32'hA1, 32'hB1);
    checks++;
    if (bus.unit_valid !== 3'b001 || bus.unit_src_addr !== 32'hA0) begin
      errors++;
      $display("FAIL b2b_first got valid=%b src=%h exp 001/a0", bus.unit_valid, bus.unit_src_addr);
    end
    tick();
    checks++;
    if (bus.unit_valid !== 3'b000 || queue_level !== 3'd1) begin
      errors++;
      $display("FAIL b2b_stall_head got valid=%b lvl=%0d exp 000/1", bus.unit_valid, queue_level);
    end
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.unit_valid !== 3'b000) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL b2b_early_issue got 1 exp 0"); end
    bus.unit_done = 3'b001;
    tick();
    bus.unit_done = 3'b000;
    checks++;
    if (bus.unit_valid !== 3'b000) begin errors++; $display("FAIL b2b_decode_cycle got %b exp 000", bus.unit_valid); end
    tick();
    checks++;
    if (bus.unit_valid !== 3'b001 || bus.unit_src_addr !== 32'hA1 || bus.unit_is_store !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got valid=%b src=%h st=%b exp 001/a1/1", bus.unit_valid, bus.unit_src_addr, bus.unit_is_store);
    end
    tick();
    bus.unit_done = 3'b001;
    tick();
    bus.unit_done = 3'b000;
  endtask

  task automatic test_sync();
    bit early;
    bit seen;
    int n;
    bus.unit_ready = 3'b111;
    push_cmd(3'd3, 32'h1, 32'h2);
    push_cmd(3'd5, 32'h0, 32'h0);
    push_cmd(3'd4, 32'h5, 32'h6);
    early = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.unit_valid[2] !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL sync_barrier got act issued exp blocked"); end
    bus.unit_done = 3'b010;
    tick();
    bus.unit_done = 3'b000;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (bus.unit_valid === 3'b100) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || bus.unit_src_addr !== 32'h5) begin
      errors++;
      $display("FAIL sync_release got seen=%b src=%h exp 1/5", seen, bus.unit_src_addr);
    end
    tick();
    bus.unit_done = 3'b100;
    tick();
    bus.unit_done = 3'b000;
  endtask

  task automatic test_timeout();
    bit early;
    int n;
    bus.unit_ready = 3'b111;
    push_cmd(3'd3, 32'h7, 32'h8);
    push_cmd(3'd5, 32'h0, 32'h0);
    push_cmd(3'd4, 32'h9, 32'hA);
    early = 1'b0;
    n = 0;
    while (err_timeout !== 1'b1 && n < 1200) begin
      if (bus.unit_valid[2] !== 1'b0) early = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (err_timeout !== 1'b1 || n < 1000 || n > 1040) begin
      errors++;
      $display("FAIL sync_timeout got err=%b after %0d cycles exp 1 after ~1025", err_timeout, n);
    end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL timeout_early_act got 1 exp 0"); end
    repeat (4) tick();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got err=%b busy=%b exp 1/1", err_timeout, busy);
    end
    bus.unit_done = 3'b110;
    tick();
    bus.unit_done = 3'b000;
  endtask

  task automatic test_halt_full();
    int n;
    bus.unit_ready = 3'b000;
    push_cmd(3'd1, 32'hC0, 32'hD0);
    push_cmd(3'd7, 32'h0, 32'h0);
    push_cmd(3'd0, 32'h0, 32'h0);
    push_cmd(3'd0, 32'h0, 32'h0);
    push_cmd(3'd0, 32'h0, 32'h0);
    bus.in_opcode = 3'd0;
    bus.in_valid  = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.in_ready !== 1'b0 || queue_level !== 3'd4) begin
      errors++;
      $display("FAIL full_block got rdy=%b lvl=%0d exp 0/4", bus.in_ready, queue_level);
    end
    bus.unit_ready = 3'b111;
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || queue_level !== 3'd3 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL halted_state got h=%b lvl=%0d rdy=%b exp 1/3/0", halted, queue_level, bus.in_ready);
    end
    repeat (3) tick();
    checks++;
    if (halted !== 1'b1 || queue_level !== 3'd3) begin
      errors++;
      $display("FAIL halted_retain got h=%b lvl=%0d exp 1/3", halted, queue_level);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if (halted !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL resume got h=%b rdy=%b exp 0/1", halted, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (queue_level !== 3'd3) begin errors++; $display("FAIL resume_pop_push got %0d exp 3", queue_level); end
    n = 0;
    while (queue_level !== 3'd0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (queue_level !== 3'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain got lvl=%0d rdy=%b exp 0/1", queue_level, bus.in_ready);
    end
    bus.unit_done = 3'b001;
    tick();
    bus.unit_done = 3'b000;
  endtask

  task automatic test_illegal_spurious();
    push_cmd(3'd6, 32'hEE, 32'hFF);
    tick();
    checks++;
    if (err_illegal !== 1'b1 || bus.unit_valid !== 3'b000 || queue_level !== 3'd0) begin
      errors++;
      $display("FAIL illegal got err=%b valid=%b lvl=%0d exp 1/000/0", err_illegal, bus.unit_valid, queue_level);
    end
    checks++;
    if (err_spurious !== 1'b0) begin errors++; $display("FAIL spurious_pre got %b exp 0", err_spurious); end
    bus.unit_done = 3'b100;
    tick();
    bus.unit_done = 3'b000;
    checks++;
    if (err_spurious !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious got err=%b busy=%b exp 1/0", err_spurious, busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.unit_ready = 3'b000;
    push_cmd(3'd1, 32'h300, 32'h400);
    push_cmd(3'd0, 32'h0, 32'h0);
    push_cmd(3'd0, 32'h0, 32'h0);
    checks++;
    if (bus.unit_valid !== 3'b001 || queue_level !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset got valid=%b lvl=%0d exp 001/2", bus.unit_valid, queue_level);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.unit_valid !== 3'b000 || queue_level !== 3'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got valid=%b lvl=%0d rdy=%b exp 000/0/1", bus.unit_valid, queue_level, bus.in_ready);
    end
    checks++;
    if ({err_illegal, err_spurious, err_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_errors got %b exp 000", {err_illegal, err_spurious, err_timeout});
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    resume          = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_opcode   = 3'd0;
    bus.in_src_addr = '0;
    bus.in_dst_addr = '0;
    bus.in_param1   = '0;
    bus.in_param2   = '0;
    bus.unit_ready  = 3'b000;
    bus.unit_done   = 3'b000;
    test_reset();
    test_load();
    test_issue_stall();
    test_back_to_back();
    test_sync();
    test_timeout();
    test_halt_full();
    test_illegal_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
